// File: rtl/branch_predict_ctrl_if.sv
// Execute-stage resolve, fetch lookup and redirect signals for branch_predict_ctrl.
// The master side is the pipeline (fetch + execute); the slave side is the controller.
interface branch_predict_ctrl_if;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [2:0]  ex_br_type;
   logic [31:0] ex_rdata1;
   logic [31:0] ex_rdata2;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic        flush;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        redir_ready;
   logic [31:0] mispredict_cnt;

   modport master (
      output if_pc, ex_valid, ex_pc, ex_br_type, ex_rdata1, ex_rdata2,
             ex_target, ex_pred_taken, redir_ready,
      input  pred_taken, ex_ready, flush, redir_valid, redir_pc, mispredict_cnt
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_br_type, ex_rdata1, ex_rdata2,
             ex_target, ex_pred_taken, redir_ready,
      output pred_taken, ex_ready, flush, redir_valid, redir_pc, mispredict_cnt
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Execute-stage branch/JAL resolution with a 2-bit-counter BHT, mispredict
// flush pulse and a held redirect PC that waits for fetch to accept it.
module branch_predict_ctrl #(
   parameter int BHT_ENTRIES = 16
) (
   input logic                 clk,
   input logic                 rst,
   branch_predict_ctrl_if.slave bus
);
   localparam int IDX = $clog2(BHT_ENTRIES);

   typedef enum logic {IDLE, REDIRECT} state_e;

   state_e          state_q, state_d;
   logic [1:0]      bht_q [BHT_ENTRIES];
   logic [31:0]     redir_pc_q, redir_pc_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            flush_q, flush_d;
   logic            bht_we;
   logic            resolve;
   logic            taken;
   logic            mispredict;
   logic [IDX-1:0]  ex_idx;
   logic [IDX-1:0]  if_idx;
   logic [1:0]      bht_upd;
   logic            unused_pc_bits;

   function automatic logic eval_taken(input logic [2:0] ty, input logic [31:0] a,
                                       input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      case (ty)
         3'b001:  return a == b;
         3'b010:  return a != b;
         3'b011:  return sa < sb;
         3'b100:  return sa >= sb;
         3'b101:  return a < b;
         3'b110:  return a >= b;
         3'b111:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] sat_counter(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'd1;
      else    return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   assign ex_idx         = bus.ex_pc[IDX+1:2];
   assign if_idx         = bus.if_pc[IDX+1:2];
   assign unused_pc_bits = ^{bus.if_pc[31:IDX+2], bus.if_pc[1:0]};

   assign resolve    = bus.ex_valid && (state_q == IDLE) && (bus.ex_br_type != 3'b000);
   assign taken      = eval_taken(bus.ex_br_type, bus.ex_rdata1, bus.ex_rdata2);
   assign mispredict = taken != bus.ex_pred_taken;
   assign bht_upd    = sat_counter(bht_q[ex_idx], taken);

   // Lookup reads the registered table, so a same-cycle update is not bypassed.
   assign bus.pred_taken     = bht_q[if_idx][1];
   assign bus.ex_ready       = (state_q == IDLE);
   assign bus.redir_valid    = (state_q == REDIRECT);
   assign bus.redir_pc       = redir_pc_q;
   assign bus.flush          = flush_q;
   assign bus.mispredict_cnt = cnt_q;

   always_comb begin
      state_d    = state_q;
      redir_pc_d = redir_pc_q;
      cnt_d      = cnt_q;
      flush_d    = 1'b0;
      bht_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (resolve) begin
               bht_we = (bus.ex_br_type != 3'b111);
               if (mispredict) begin
                  redir_pc_d = taken ? bus.ex_target : bus.ex_pc + 32'd4;
                  cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
                  flush_d    = 1'b1;
                  state_d    = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            if (bus.redir_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         redir_pc_q <= 32'd0;
         cnt_q      <= 32'd0;
         flush_q    <= 1'b0;
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         state_q    <= state_d;
         redir_pc_q <= redir_pc_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
         if (bht_we) bht_q[ex_idx] <= bht_upd;
      end
   end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vector table plus randomized traffic
// checked against a behavioural model of the resolve/redirect rules.
module tb_branch_predict_ctrl;
   logic clk;
   logic rst;

   branch_predict_ctrl_if bus ();

   branch_predict_ctrl #(.BHT_ENTRIES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Behavioural model state
   int          m_bht [16];
   bit          m_pend;
   bit          m_flush;
   logic [31:0] m_rpc;
   longint      m_cnt;

   typedef struct {
      logic        rst;
      logic        v;
      logic [2:0]  ty;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pr;
      logic        rr;
      logic [31:0] ifpc;
      logic        e_flush;
      logic        e_rv;
      logic [31:0] e_rpc;
      logic [31:0] e_cnt;
      logic        e_rdy;
      logic        e_pt;
   } vec_t;

   vec_t tbl [28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit ref_taken(input logic [2:0] ty, input logic [31:0] a,
                                    input logic [31:0] b);
      case (ty)
         3'd1: return a == b;
         3'd2: return a != b;
         3'd3: return $signed(a) < $signed(b);
         3'd4: return $signed(a) >= $signed(b);
         3'd5: return a < b;
         3'd6: return a >= b;
         3'd7: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_pend  = 0;
      m_flush = 0;
      m_rpc   = 32'd0;
      m_cnt   = 0;
   endtask

   // Applies the rules for the edge just taken, using the inputs still held.
   task automatic model_edge();
      bit t;
      int k;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_pend) begin
         m_flush = 0;
         if (bus.redir_ready) m_pend = 0;
         return;
      end
      m_flush = 0;
      if (bus.ex_valid && bus.ex_br_type != 3'd0) begin
         t = ref_taken(bus.ex_br_type, bus.ex_rdata1, bus.ex_rdata2);
         k = int'(bus.ex_pc[5:2]);
         if (bus.ex_br_type != 3'd7)
            m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                         : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
         if (t != bus.ex_pred_taken) begin
            m_rpc   = t ? bus.ex_target : bus.ex_pc + 32'd4;
            m_cnt   = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
            m_pend  = 1;
            m_flush = 1;
         end
      end
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pr, input logic rr,
                        input logic [31:0] ifpc);
      rst               = r;
      bus.ex_valid      = v;
      bus.ex_br_type    = ty;
      bus.ex_rdata1     = a;
      bus.ex_rdata2     = b;
      bus.ex_pc         = pc;
      bus.ex_target     = tgt;
      bus.ex_pred_taken = pr;
      bus.redir_ready   = rr;
      bus.if_pc         = ifpc;
   endtask

   task automatic chk_model();
      chk("rnd_flush",       {31'd0, bus.flush},       {31'd0, m_flush});
      chk("rnd_redir_valid", {31'd0, bus.redir_valid}, {31'd0, m_pend});
      chk("rnd_ex_ready",    {31'd0, bus.ex_ready},    {31'd0, !m_pend});
      chk("rnd_redir_pc",    bus.redir_pc,             m_rpc);
      chk("rnd_cnt",         bus.mispredict_cnt,       m_cnt[31:0]);
      chk("rnd_pred_taken",  {31'd0, bus.pred_taken},
          {31'd0, (m_bht[bus.if_pc[5:2]] >= 2)});
   endtask

   initial begin
      //          rst v  ty    a             b          pc            tgt          pr rr ifpc         fl rv rpc          cnt rdy pt
      tbl[0]  = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h0,       0, 0, 32'h0,       0, 1, 0};
      tbl[1]  = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h3C,      0, 0, 32'h0,       0, 1, 0};
      tbl[2]  = '{0, 1, 3'd1, 32'd5,        32'd5,     32'h100,      32'h80,      0, 1, 32'h100,     0, 0, 32'h0,       0, 1, 0};
      tbl[3]  = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h100,     1, 1, 32'h80,      1, 0, 1};
      tbl[4]  = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h100,     0, 0, 32'h80,      1, 1, 1};
      tbl[5]  = '{0, 1, 3'd3, 32'hFFFFFFFF, 32'd1,     32'h200,      32'h300,     1, 1, 32'h200,     0, 0, 32'h80,      1, 1, 1};
      tbl[6]  = '{0, 1, 3'd5, 32'hFFFFFFFF, 32'd1,     32'h204,      32'h300,     1, 1, 32'h204,     0, 0, 32'h80,      1, 1, 0};
      tbl[7]  = '{0, 1, 3'd1, 32'd7,        32'd7,     32'h204,      32'h500,     0, 0, 32'h204,     1, 1, 32'h208,     2, 0, 0};
      tbl[8]  = '{0, 1, 3'd1, 32'd7,        32'd7,     32'h204,      32'h500,     0, 0, 32'h204,     0, 1, 32'h208,     2, 0, 0};
      tbl[9]  = '{0, 1, 3'd1, 32'd7,        32'd7,     32'h204,      32'h500,     0, 0, 32'h204,     0, 1, 32'h208,     2, 0, 0};
      tbl[10] = '{0, 1, 3'd1, 32'd7,        32'd7,     32'h204,      32'h500,     0, 1, 32'h204,     0, 1, 32'h208,     2, 0, 0};
      tbl[11] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h204,     0, 0, 32'h208,     2, 1, 0};
      tbl[12] = '{0, 1, 3'd2, 32'd1,        32'd2,     32'h8,        32'h600,     1, 1, 32'h8,       0, 0, 32'h208,     2, 1, 0};
      tbl[13] = '{0, 1, 3'd2, 32'd1,        32'd2,     32'h8,        32'h600,     1, 1, 32'h8,       0, 0, 32'h208,     2, 1, 1};
      tbl[14] = '{0, 1, 3'd2, 32'd1,        32'd2,     32'h8,        32'h600,     1, 1, 32'h8,       0, 0, 32'h208,     2, 1, 1};
      tbl[15] = '{0, 1, 3'd2, 32'd1,        32'd2,     32'h8,        32'h600,     1, 1, 32'h8,       0, 0, 32'h208,     2, 1, 1};
      tbl[16] = '{0, 1, 3'd2, 32'd3,        32'd3,     32'h8,        32'h600,     0, 1, 32'h8,       0, 0, 32'h208,     2, 1, 1};
      tbl[17] = '{0, 1, 3'd7, 32'd0,        32'd0,     32'h8,        32'h1000,    0, 1, 32'h8,       0, 0, 32'h208,     2, 1, 1};
      tbl[18] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h8,       1, 1, 32'h1000,    3, 0, 1};
      tbl[19] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h8,       0, 0, 32'h1000,    3, 1, 1};
      tbl[20] = '{0, 1, 3'd1, 32'd9,        32'd9,     32'h10,       32'h40,      0, 0, 32'h8,       0, 0, 32'h1000,    3, 1, 1};
      tbl[21] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 0, 32'h8,       1, 1, 32'h40,      4, 0, 1};
      tbl[22] = '{1, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 0, 32'h8,       0, 1, 32'h40,      4, 0, 1};
      tbl[23] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 0, 32'h8,       0, 0, 32'h0,       0, 1, 0};
      tbl[24] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h0,       0, 0, 32'h0,       0, 1, 0};
      tbl[25] = '{0, 1, 3'd1, 32'd1,        32'd2,     32'hFFFFFFFC, 32'h700,     1, 1, 32'h0,       0, 0, 32'h0,       0, 1, 0};
      tbl[26] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h0,       1, 1, 32'h0,       1, 0, 0};
      tbl[27] = '{0, 0, 3'd0, 32'd0,        32'd0,     32'h0,        32'h0,       0, 1, 32'h0,       0, 0, 32'h0,       1, 1, 0};

      n_vec = 0;
      n_err = 0;
      model_reset();

      drive(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      clock_edge();

      for (int i = 0; i < 28; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].ty, tbl[i].a, tbl[i].b, tbl[i].pc,
               tbl[i].tgt, tbl[i].pr, tbl[i].rr, tbl[i].ifpc);
         #3;
         chk($sformatf("v%0d_flush", i),       {31'd0, bus.flush},       {31'd0, tbl[i].e_flush});
         chk($sformatf("v%0d_redir_valid", i), {31'd0, bus.redir_valid}, {31'd0, tbl[i].e_rv});
         chk($sformatf("v%0d_redir_pc", i),    bus.redir_pc,             tbl[i].e_rpc);
         chk($sformatf("v%0d_cnt", i),         bus.mispredict_cnt,       tbl[i].e_cnt);
         chk($sformatf("v%0d_ex_ready", i),    {31'd0, bus.ex_ready},    {31'd0, tbl[i].e_rdy});
         chk($sformatf("v%0d_pred_taken", i),  {31'd0, bus.pred_taken},  {31'd0, tbl[i].e_pt});
         clock_edge();
      end

      drive(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      clock_edge();

      for (int c = 0; c < 3000; c++) begin
         logic [31:0] a, b, pc;
         b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         case ($urandom_range(0, 3))
            0:       a = b;
            1:       a = ~b;
            2:       a = 32'($urandom_range(0, 3));
            default: a = $urandom;
         endcase
         pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {26'($urandom), 6'($urandom) & 6'h3C};
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), a, b, pc, $urandom, 1'($urandom),
               ($urandom_range(0, 2) != 0), {26'($urandom), 6'($urandom)});
         #3;
         chk_model();
         clock_edge();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Control-flow resolution controller for the pipelined RV32I core. Sits at the execute stage: it resolves conditional branches and JAL, and keeps a 2-bit-counter branch history table (BHT) that feeds fetch predictions. On a mispredict it issues a one-cycle pipeline flush and holds a redirect PC until fetch accepts it.

## Interface
- BHT_ENTRIES, 16: number of 2-bit counters; power of 2, range 2..256; IDX = log2(BHT_ENTRIES).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch-stage PC used for lookup.
- pred_taken  out  1  combinational prediction for if_pc: MSB of BHT[if_pc[IDX+1:2]].
- ex_valid  in  1  execute-stage control-flow op is present.
- ex_ready  out  1  controller can accept a resolve this cycle.
- ex_pc  in  32  PC of the resolving instruction.
- ex_br_type  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 JAL.
- ex_rdata1, ex_rdata2  in  32  register operands.
- ex_target  in  32  computed taken target.
- ex_pred_taken  in  1  prediction this instruction was fetched with.
- flush  out  1  one-cycle pulse that kills younger instructions.
- redir_valid  out  1  redirect PC valid.
- redir_pc  out  32  redirect destination.
- redir_ready  in  1  fetch accepts the redirect.
- mispredict_cnt  out  32  saturating mispredict counter.

## Operation
- FSM states: IDLE, REDIRECT. Reset state is IDLE.
- IDLE: ex_ready=1, redir_valid=0.
- A resolve occurs when ex_valid && ex_ready.
- Taken evaluation:
  - BEQ: ==. BNE: !=.
  - BLT and BGE compare signed operands.
  - BLTU and BGEU compare unsigned operands.
  - JAL is always taken.
  - Type 000 is never taken and causes no state change.
- Mispredict = (taken != ex_pred_taken), evaluated for types 001-111.
- BHT update on resolve, for types 001-110 only (not JAL, not 000):
  - counter at ex_pc[IDX+1:2] increments if taken and decrements if not.
  - counters saturate at 11 and 00.
- On mispredict:
  - latch redir_pc = taken ? ex_target : ex_pc + 32'd4. The add wraps modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
  - mispredict_cnt increments; it holds at 0xFFFFFFFF.
  - FSM goes to REDIRECT.
- No mispredict: stay in IDLE; no flush, no redirect.
- REDIRECT:
  - ex_ready=0; redir_valid=1.
  - redir_pc is held stable until redir_valid && redir_ready.
  - On that handshake, return to IDLE.
- flush is high exactly in the first cycle of REDIRECT only, even if redir_ready stays low.
- Resolve and lookup at the same BHT index in the same cycle: pred_taken reflects the pre-update value.
- Reset at any point, including mid-REDIRECT:
  - FSM goes to IDLE; pending redirect is dropped.
  - flush=0, redir_valid=0, redir_pc=0, mispredict_cnt=0.
  - all BHT counters = 01 (weakly not-taken), so pred_taken=0 for every PC.
- ex_valid while ex_ready=0 is ignored; the pipeline must hold the op until ex_ready returns.

## Timing
- Resolve in cycle N with a mispredict:
  - flush=1 and redir_valid=1 in N+1.
  - If redir_ready=1 in N+1: IDLE and ex_ready=1 in N+2.
  - Minimum redirect latency is 1 cycle; throughput is one resolve per 2 cycles on back-to-back mispredicts.
- Correctly predicted resolves: one per cycle, zero stall; BHT write visible to pred_taken from N+1.
- mispredict_cnt updates at the end of cycle N, so it is visible in N+1.
- Redirect backpressure: each extra cycle of redir_ready=0 extends REDIRECT by one cycle; flush does not re-pulse.

## Test plan
- Reset: assert rst 2 cycles -> flush=0, redir_valid=0, redir_pc=0, mispredict_cnt=0, ex_ready=1, pred_taken=0 for if_pc=0x0 and 0x3C.
- BEQ, rdata1=rdata2=5, pred 0, ex_pc=0x100, target=0x80 -> N+1: flush=1, redir_valid=1, redir_pc=0x80, cnt=1; BHT[0] becomes 10 and pred_taken(if_pc=0x100)=1.
- Signedness: rdata1=0xFFFFFFFF, rdata2=1, pred 1:
  - BLT -> taken, no redirect.
  - BLTU -> not taken, mispredict, redir_pc=ex_pc+4.
- Backpressure: mispredict with redir_ready=0 for 3 cycles, then 1 -> flush high only the first cycle; redir_pc stable; ex_ready=0 for 4 cycles; ex_valid pulses during REDIRECT cause no BHT or cnt change.
- Saturation: 4 taken BNE resolves at one index -> counter 11; 1 not-taken -> 10, pred_taken still 1; JAL with pred 0 -> redirect to target, BHT unchanged.
- Reset mid-REDIRECT with redir_ready=0 -> next cycle IDLE, redir_valid=0, cnt=0, BHT back to 01.
